scan_pattern_ctrl: RTL and testbench



---
 rtl/scan_pattern_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_scan_pattern_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// scan_pattern_ctrl
//
// Sequencer for a single scan chain built from mux-D scan flops. For each
// accepted request it shifts a parallel pattern into the chain (MSB first so
// that flop i ends up holding pattern[i]), drops SE for exactly one functional
// capture cycle, then shifts the captured response out and presents it as a
// parallel word behind a valid/ready handshake.
//
// Parameters
//   CHAIN_LEN  number of flops in the chain (L), must be >= 2
//   FILL       value driven on scan_si while the response is unloaded
//
// Ports
//   CLK         chain and controller clock (all state on posedge)
//   RSTB        asynchronous active-low reset
//   start       request, accepted only while idle
//   abort       synchronous abort, returns to idle on the next edge
//   pattern     pattern to load, sampled on the accepting edge
//   busy        high whenever the sequencer is not idle
//   scan_se     scan enable to every chain flop (registered)
//   scan_si     scan input to chain flop 0 (registered)
//   scan_so     Q of the last chain flop (flop L-1)
//   resp        captured response, resp[i] = flop i after capture (registered)
//   resp_valid  response available (registered)
//   resp_ready  consumer accepts the response
// -----------------------------------------------------------------------------
module scan_pattern_ctrl #(
  parameter int unsigned CHAIN_LEN = 16,
  parameter logic        FILL      = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern,
  output logic                 busy,
  output logic                 scan_se,
  output logic                 scan_si,
  input  logic                 scan_so,
  output logic [CHAIN_LEN-1:0] resp,
  output logic                 resp_valid,
  input  logic                 resp_ready
);

  localparam int unsigned            CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0]       CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]       CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CHAIN_LEN-1:0]   VEC_ZERO = {CHAIN_LEN{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Holds the bits still to be shifted, left-aligned: bit L-1 is always the
  // next value for scan_si. Loaded pre-shifted by one on the accepting edge
  // because pattern[L-1] goes straight to scan_si on that same edge.
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 valid_q, valid_d;

  // State register plus every registered output.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      pat_q   <= VEC_ZERO;
      resp_q  <= VEC_ZERO;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      resp_q  <= resp_d;
      se_q    <= se_d;
      si_q    <= si_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and phase counter; abort outranks every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // An abort in idle also masks a simultaneous start.
        if (start && !abort) begin
          state_d = S_SHIFT;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_UNLOAD;
        end
        cnt_d = CNT_ZERO;
      end
      S_UNLOAD: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
        cnt_d = CNT_ZERO;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Next values of the registered outputs, decoded from the transition being
  // taken so that each output lines up with the state it belongs to.
  always_comb begin
    pat_d   = pat_q;
    resp_d  = resp_q;
    si_d    = 1'b0;
    se_d    = (state_d == S_SHIFT) || (state_d == S_UNLOAD);
    valid_d = (state_d == S_DONE);

    if ((state_q == S_IDLE) && (state_d == S_SHIFT)) begin
      si_d  = pattern[CHAIN_LEN-1];
      pat_d = {pattern[CHAIN_LEN-2:0], 1'b0};
    end else if ((state_q == S_SHIFT) && (state_d == S_SHIFT)) begin
      si_d  = pat_q[CHAIN_LEN-1];
      pat_d = {pat_q[CHAIN_LEN-2:0], 1'b0};
    end else if (state_d == S_UNLOAD) begin
      si_d  = FILL;
    end else begin
      si_d  = 1'b0;
    end

    // scan_so is sampled with the pre-edge value on each unload edge; the
    // first sample is flop L-1 and ends up in resp[L-1] after L shifts.
    // The edge that takes an abort leaves resp untouched.
    if ((state_q == S_UNLOAD) && !abort) begin
      resp_d = {resp_q[CHAIN_LEN-2:0], scan_so};
    end else begin
      resp_d = resp_q;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign scan_se    = se_q;
  assign scan_si    = si_q;
  assign resp       = resp_q;
  assign resp_valid = valid_q;

endmodule

// File: tb/tb_scan_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for scan_pattern_ctrl (L = 16). A behavioural scan chain sits around
// the DUT; its functional D inputs are forced per transaction. Each accepted
// request pushes its pattern, forced capture data and accept cycle into a
// queue; a negedge monitor derives the expected cycle-by-cycle behaviour from
// the accept cycle and pops the entry once the response has been handed off.
// -----------------------------------------------------------------------------
module tb_scan_pattern_ctrl;

  localparam int   L      = 16;
  localparam logic FILL_V = 1'b0;

  logic         CLK        = 1'b0;
  logic         RSTB       = 1'b0;
  logic         start      = 1'b0;
  logic         abort      = 1'b0;
  logic         resp_ready = 1'b0;
  logic [L-1:0] pattern    = '0;
  logic         busy, scan_se, scan_si, scan_so, resp_valid;
  logic [L-1:0] resp;

  logic [L-1:0] chain  = '0;
  logic [L-1:0] func_d = '0;
  int           cyc    = 0;
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    logic [L-1:0] p;
    logic [L-1:0] d;
    int           a;
    int           ab;
  } exp_t;

  exp_t q[$];
  bit   rel_pend = 1'b0;
  exp_t me;
  int   mk;

  scan_pattern_ctrl #(.CHAIN_LEN(L), .FILL(FILL_V)) dut (
    .CLK        (CLK),
    .RSTB       (RSTB),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .busy       (busy),
    .scan_se    (scan_se),
    .scan_si    (scan_si),
    .scan_so    (scan_so),
    .resp       (resp),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready)
  );

  always #5 CLK = ~CLK;

  // Behavioural chain: flop 0 takes SI, flop i takes flop i-1; D when SE low.
  assign scan_so = chain[L-1];
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (scan_se) chain <= {chain[L-2:0], scan_si};
    else         chain <= func_d;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: k = cycles since the accepting edge.
  // k 0..L-1 shift, k L capture, k L+1..2L unload, k >= 2L+1 done.
  always @(negedge CLK) begin
    if (!RSTB) begin
      rel_pend = 1'b0;
    end else if (q.size() == 0) begin
      chk("idle", {29'd0, busy, scan_se, resp_valid}, 32'd0);
    end else begin
      me = q[0];
      mk = cyc - me.a;
      if (rel_pend) begin
        chk("release", {29'd0, busy, scan_se, resp_valid}, 32'd0);
        void'(q.pop_front());
        rel_pend = 1'b0;
      end else if (mk < 0) begin
        chk("pre_accept", {31'd0, busy}, 32'd0);
      end else if (me.ab > 0 && mk >= me.ab) begin
        chk("abort", {29'd0, busy, scan_se, resp_valid}, 32'd0);
        void'(q.pop_front());
      end else if (mk < L) begin
        chk("shift", {28'd0, busy, scan_se, scan_si, resp_valid},
            {28'd0, 1'b1, 1'b1, me.p[L-1-mk], 1'b0});
      end else if (mk == L) begin
        chk("capture_ctl", {29'd0, busy, scan_se, resp_valid}, {29'd0, 3'b100});
        chk("chain_loaded", 32'(chain), 32'(me.p));
      end else if (mk <= 2 * L) begin
        chk("unload", {28'd0, busy, scan_se, scan_si, resp_valid},
            {28'd0, 1'b1, 1'b1, FILL_V, 1'b0});
      end else begin
        chk("done_ctl", {29'd0, busy, scan_se, resp_valid}, {29'd0, 3'b101});
        chk("resp", 32'(resp), 32'(me.d));
        if (resp_ready) rel_pend = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drive start for the next edge and record what that request must produce.
  task automatic issue(input logic [L-1:0] p, input logic [L-1:0] d, input int ab);
    exp_t e;
    e.p = p;
    e.d = d;
    e.a = cyc + 1;
    e.ab = ab;
    q.push_back(e);
    start   = 1'b1;
    pattern = p;
    func_d  = d;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    int a;
    logic [L-1:0] p, d;

    repeat (2) step();
    chk("reset_ctl", {28'd0, busy, scan_se, scan_si, resp_valid}, 32'd0);
    chk("reset_resp", 32'(resp), 32'd0);
    #2 RSTB = 1'b1;
    step();

    // Random patterns and capture data, consumer always ready.
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p = L'($urandom);
      d = L'($urandom);
      issue(p, d, 0);
      wait_idle(4 * L);
      repeat (i % 3) step();
    end

    // Consumer stalls 5 cycles in DONE; start pulses there must be ignored.
    resp_ready = 1'b0;
    a = cyc + 1;
    issue(L'($urandom), L'($urandom), 0);
    while (cyc < a + 2 * L + 1) step();
    for (int i = 0; i < 5; i++) begin
      start   = (i == 1 || i == 3);
      pattern = ~pattern;
      step();
    end
    start      = 1'b0;
    resp_ready = 1'b1;
    wait_idle(4 * L);

    // Abort together with start while idle: nothing is accepted.
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    repeat (2) step();

    // Abort during the second unload cycle, then a clean request.
    a = cyc + 1;
    issue(L'($urandom), L'($urandom), L + 3);
    while (cyc < a + L + 2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_idle(4 * L);
    issue(L'($urandom), L'($urandom), 0);
    wait_idle(4 * L);

    // Asynchronous reset in the middle of shifting.
    a = cyc + 1;
    issue(L'($urandom), L'($urandom), 0);
    while (cyc < a + 5) step();
    #1 RSTB = 1'b0;
    q.delete();
    #1;
    chk("async_reset_ctl", {28'd0, busy, scan_se, scan_si, resp_valid}, 32'd0);
    chk("async_reset_resp", 32'(resp), 32'd0);
    repeat (2) step();
    #1 RSTB = 1'b1;
    step();
    issue(L'($urandom), L'($urandom), 0);
    wait_idle(4 * L);

    // Back-to-back: second accept lands 2 edges after the first resp_valid.
    resp_ready = 1'b1;
    a = cyc + 1;
    issue(16'hA5C3, 16'h5AF0, 0);
    while (cyc < a + 2 * L + 2) step();
    issue(16'h0001, 16'hC3A5, 0);
    wait_idle(8 * L);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
